// File: rtl/uart_rx_tx.sv
// Full-duplex 8N1 UART: independent transmitter and receiver on one clock,
// with a runtime-selectable baud rate. Each direction latches its baud
// select at the start of its own frame, so a mid-frame change only affects
// the next frame.
//
// Handshake: uart_tx_ready=1 means the transmitter is idle. A frame is
// accepted on any rising edge where uart_tx_ready=1 and uart_tx_start=1;
// the byte is captured on that edge. uart_rx_valid is a one-clock pulse
// coinciding with the update of uart_received_data.
module uart_rx_tx #(
    parameter int CLOCK_FREQ = 10_000_000
) (
    input  logic       clk_int,
    input  logic       uart_reset,
    input  logic [7:0] uart_transmit_data,
    input  logic       uart_rx_d_in,
    input  logic       uart_tx_start,
    output logic       uart_tx_d_out,
    input  logic [1:0] freq_control,
    output logic [7:0] uart_received_data,
    output logic       uart_rx_valid,
    output logic       uart_tx_ready
);

    // Clocks per bit for each baud code (integer truncation).
    localparam logic [15:0] DIV_0 = 16'(CLOCK_FREQ / 1_500_000);
    localparam logic [15:0] DIV_1 = 16'(CLOCK_FREQ / 921_600);
    localparam logic [15:0] DIV_2 = 16'(CLOCK_FREQ / 115_200);
    localparam logic [15:0] DIV_3 = 16'(CLOCK_FREQ / 9_600);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    logic [15:0] div_sel_d;

    tx_state_t   tx_state_q;
    logic [15:0] tx_cnt_q;
    logic [15:0] tx_div_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  tx_shift_q;
    logic        tx_line_q;
    logic        tx_ready_q;

    rx_state_t   rx_state_q;
    logic [15:0] rx_cnt_q;
    logic [15:0] rx_div_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q;
    logic        rx_s1_q;
    logic        rx_s2_q;
    logic        rx_s3_q;

    assign uart_tx_d_out      = tx_line_q;
    assign uart_tx_ready      = tx_ready_q;
    assign uart_received_data = rx_data_q;
    assign uart_rx_valid      = rx_valid_q;

    // Map the baud select code to a bit divisor.
    always_comb begin
        div_sel_d = DIV_3;
        case (freq_control)
            2'b00:   div_sel_d = DIV_0;
            2'b01:   div_sel_d = DIV_1;
            2'b10:   div_sel_d = DIV_2;
            default: div_sel_d = DIV_3;
        endcase
    end

    // Transmit FSM: start bit, 8 data bits LSB first, stop bit, DIV clocks each.
    always_ff @(posedge clk_int) begin
        if (uart_reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= DIV_0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
            tx_ready_q <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (uart_tx_start) begin
                        tx_shift_q <= uart_transmit_data;
                        tx_div_q   <= div_sel_d;
                        tx_cnt_q   <= '0;
                        tx_line_q  <= 1'b0;
                        tx_ready_q <= 1'b0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == tx_div_q - 16'd1) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_line_q  <= tx_shift_q[0];
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == tx_div_q - 16'd1) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            tx_line_q  <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            tx_line_q  <= tx_shift_q[0];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == tx_div_q - 16'd1) begin
                        tx_cnt_q   <= '0;
                        tx_ready_q <= 1'b1;
                        tx_state_q <= TX_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    // Receive FSM behind a 2-flop synchronizer. The start bit is re-checked
    // two clocks before DIV/2 because the synchronizer and edge detector
    // already add that much delay; data and stop bits follow every DIV clocks.
    always_ff @(posedge clk_int) begin
        if (uart_reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= DIV_0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            rx_s1_q    <= uart_rx_d_in;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            rx_valid_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_s3_q && !rx_s2_q) begin
                        rx_cnt_q   <= '0;
                        rx_div_q   <= div_sel_d;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == (rx_div_q >> 1) - 16'd2) begin
                        rx_cnt_q <= '0;
                        rx_bit_q <= '0;
                        if (rx_s2_q) begin
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_state_q <= RX_DATA;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == rx_div_q - 16'd1) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == rx_div_q - 16'd1) begin
                        rx_cnt_q <= '0;
                        if (rx_s2_q) begin
                            rx_data_q  <= rx_shift_q;
                            rx_valid_q <= 1'b1;
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_state_q <= RX_WAIT_HIGH;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_s2_q) begin
                        rx_state_q <= RX_IDLE;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_tx.sv
// Bench for uart_rx_tx: loopback frames checked clock by clock against an
// 8N1 frame model, plus a directly driven receive line for framing errors
// and glitches. Received bytes are matched against an expected queue.
module tb_uart_rx_tx;

    localparam int CLK_HZ = 10_000_000;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [1:0] freq;
    logic       loop_en;
    logic       rx_drv;
    logic       rx_line;
    logic       tx_out;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_ready;

    int n_cmp = 0;
    int n_err = 0;
    int valid_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_last = 8'h00;

    assign rx_line = loop_en ? tx_out : rx_drv;

    uart_rx_tx #(.CLOCK_FREQ(CLK_HZ)) dut (
        .clk_int           (clk),
        .uart_reset        (rst),
        .uart_transmit_data(tx_data),
        .uart_rx_d_in      (rx_line),
        .uart_tx_start     (tx_start),
        .uart_tx_d_out     (tx_out),
        .freq_control      (freq),
        .uart_received_data(rx_data),
        .uart_rx_valid     (rx_valid),
        .uart_tx_ready     (tx_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Clocks per bit from the baud table.
    function automatic int div_of(input logic [1:0] code);
        int baud;
        case (code)
            2'd0:    baud = 1_500_000;
            2'd1:    baud = 921_600;
            2'd2:    baud = 115_200;
            default: baud = 9_600;
        endcase
        return CLK_HZ / baud;
    endfunction

    // Scoreboard: every valid pulse must match the oldest expected byte.
    always @(negedge clk) begin
        if (!rst && rx_valid === 1'b1) begin
            valid_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rx_unexpected: got valid with data %02h, expected no frame", rx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                exp_last = e;
                if (rx_data !== e) begin
                    n_err++;
                    $display("FAIL rx_data: got %02h expected %02h", rx_data, e);
                end
            end
        end
    end

    task automatic wait_rx_drain(input int budget, input string tag);
        for (int k = 0; k < budget && exp_q.size() != 0; k++) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: got %0d bytes outstanding expected 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Send one byte in loopback and check every clock of the TX line.
    task automatic send_frame_check(input logic [7:0] b, input logic [1:0] code, input string tag);
        logic [9:0] frame;
        int d;
        int bad;
        frame = {1'b1, b, 1'b0};
        d = div_of(code);
        bad = 0;
        @(negedge clk);
        tx_data = b;
        freq = code;
        tx_start = 1'b1;
        n_cmp++;
        if (tx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s_ready_before: got %b expected 1", tag, tx_ready);
        end
        exp_q.push_back(b);
        @(negedge clk);
        tx_start = 1'b0;
        tx_data = 8'($urandom);
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < d; j++) begin
                if (i == 2 && j == 0) freq = 2'($urandom_range(0, 3));
                n_cmp++;
                if (tx_out !== frame[i] || tx_ready !== 1'b0) begin
                    n_err++;
                    if (bad < 3)
                        $display("FAIL %s_line bit%0d clk%0d: got line=%b ready=%b expected line=%b ready=0",
                                 tag, i, j, tx_out, tx_ready, frame[i]);
                    bad++;
                end
                @(negedge clk);
            end
        end
        n_cmp++;
        if (tx_ready !== 1'b1 || tx_out !== 1'b1) begin
            n_err++;
            $display("FAIL %s_end: got ready=%b line=%b expected 1 1", tag, tx_ready, tx_out);
        end
        wait_rx_drain(4 * d, tag);
    endtask

    // Drive one 8N1 frame onto the receive pin with a chosen stop bit.
    task automatic drive_rx(input logic [7:0] b, input logic stop_bit, input int d);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = frame[i];
            repeat (d) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        loop_en = 1'b0;
        rx_drv = 1'b1;
        tx_start = 1'b0;
        tx_data = 8'h00;
        freq = 2'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (tx_out !== 1'b1 || tx_ready !== 1'b1 || rx_valid !== 1'b0 || rx_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset: got line=%b ready=%b valid=%b data=%02h expected 1 1 0 00",
                     tx_out, tx_ready, rx_valid, rx_data);
        end
        rst = 1'b0;
        @(negedge clk);
        loop_en = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_loop_basic();
        send_frame_check(8'h02, 2'd0, "basic");
    endtask

    task automatic test_freq_codes();
        for (int c = 0; c < 4; c++) send_frame_check(8'hA5, 2'(c), "freq");
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++)
            send_frame_check(8'($urandom), 2'($urandom_range(0, 2)), "rand");
    endtask

    task automatic test_back_to_back();
        int v0;
        int k;
        v0 = valid_cnt;
        freq = 2'd0;
        for (int n = 0; n < 20; n++) begin
            for (k = 0; k < 200 && tx_ready !== 1'b1; k++) @(negedge clk);
            tx_data = (n % 2 == 0) ? 8'h02 : 8'h0A;
            tx_start = 1'b1;
            exp_q.push_back(tx_data);
            @(negedge clk);
            n_cmp++;
            if (tx_ready !== 1'b0 || tx_out !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_accept%0d: got ready=%b line=%b expected 0 0", n, tx_ready, tx_out);
            end
            tx_start = 1'b0;
        end
        wait_rx_drain(200, "b2b");
        repeat (20) @(negedge clk);
        n_cmp++;
        if (valid_cnt - v0 != 20) begin
            n_err++;
            $display("FAIL b2b_count: got %0d valid pulses expected 20", valid_cnt - v0);
        end
    endtask

    task automatic test_held_start();
        logic [7:0] x;
        logic [7:0] y;
        int k;
        x = 8'($urandom);
        y = 8'($urandom);
        freq = 2'd0;
        @(negedge clk);
        tx_data = x;
        tx_start = 1'b1;
        exp_q.push_back(x);
        @(negedge clk);
        tx_data = y;
        exp_q.push_back(y);
        for (k = 0; k < 80 && tx_ready !== 1'b1; k++) @(negedge clk);
        n_cmp++;
        if (tx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL held_ready: got %b expected 1 within 80 clocks", tx_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (tx_ready !== 1'b0 || tx_out !== 1'b0) begin
            n_err++;
            $display("FAIL held_restart: got ready=%b line=%b expected 0 0", tx_ready, tx_out);
        end
        tx_start = 1'b0;
        wait_rx_drain(150, "held");
    endtask

    task automatic test_rx_errors();
        int v0;
        logic [7:0] g;
        freq = 2'd0;
        loop_en = 1'b0;
        rx_drv = 1'b1;
        repeat (10) @(negedge clk);
        v0 = valid_cnt;
        drive_rx(8'h55, 1'b0, 6);
        rx_drv = 1'b0;
        repeat (12) @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (valid_cnt != v0 || rx_data !== exp_last) begin
            n_err++;
            $display("FAIL framing: got %0d pulses data=%02h expected 0 pulses data=%02h",
                     valid_cnt - v0, rx_data, exp_last);
        end
        rx_drv = 1'b0;
        repeat (2) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        n_cmp++;
        if (valid_cnt != v0 || rx_data !== exp_last) begin
            n_err++;
            $display("FAIL glitch: got %0d pulses data=%02h expected 0 pulses data=%02h",
                     valid_cnt - v0, rx_data, exp_last);
        end
        g = 8'($urandom);
        exp_q.push_back(g);
        drive_rx(g, 1'b1, 6);
        wait_rx_drain(20, "rx_recover");
        loop_en = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        freq = 2'd0;
        @(negedge clk);
        tx_data = 8'($urandom);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (25) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (tx_out !== 1'b1 || tx_ready !== 1'b1 || rx_valid !== 1'b0 || rx_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mid: got line=%b ready=%b valid=%b data=%02h expected 1 1 0 00",
                     tx_out, tx_ready, rx_valid, rx_data);
        end
        exp_last = 8'h00;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send_frame_check(8'($urandom), 2'd1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_loop_basic();
        test_freq_codes();
        test_random();
        test_back_to_back();
        test_held_start();
        test_rx_errors();
        test_reset_mid_frame();
        repeat (20) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
